// File: rtl/ysyx_exu_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap/return sequencer: CSR addresses,
// mstatus field positions, default interrupt cause and sequencer states.
package ysyx_exu_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0]  MTVEC_MODE_VEC = 2'b01;
  localparam logic [31:0] IRQ_CAUSE_DEF  = 32'h8000_0007;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SAVE  = 3'd1,
    ST_STAT  = 3'd2,
    ST_MRET  = 3'd3,
    ST_REDIR = 3'd4
  } trap_state_e;

endpackage

// File: rtl/ysyx_exu_trap_ctrl_if.sv
// Signal bundle between EXU commit / CSR file / IFU and the trap sequencer.
// master = environment side, slave = the sequencer.
interface ysyx_exu_trap_ctrl_if
  import ysyx_exu_trap_ctrl_pkg::*;
#(
  parameter int BIT_W = 32,
  parameter int R_W   = 12
);
  logic             trap_valid_i;
  logic [BIT_W-1:0] trap_cause_i;
  logic [BIT_W-1:0] trap_pc_i;
  logic             mret_valid_i;
  logic             irq_timer_i;
  logic             req_ready_o;
  logic [BIT_W-1:0] csr_mstatus_i;
  logic [BIT_W-1:0] csr_mtvec_i;
  logic [BIT_W-1:0] csr_mepc_i;
  logic             csr_wen_o;
  logic [R_W-1:0]   csr_waddr_o;
  logic [BIT_W-1:0] csr_wdata_o;
  logic [R_W-1:0]   csr_waddr_add1_o;
  logic [BIT_W-1:0] csr_wdata_add1_o;
  logic             redirect_valid_o;
  logic [BIT_W-1:0] redirect_pc_o;
  logic             redirect_ready_i;
  logic             busy_o;

  modport master (
    output trap_valid_i, trap_cause_i, trap_pc_i, mret_valid_i, irq_timer_i,
           csr_mstatus_i, csr_mtvec_i, csr_mepc_i, redirect_ready_i,
    input  req_ready_o, csr_wen_o, csr_waddr_o, csr_wdata_o, csr_waddr_add1_o,
           csr_wdata_add1_o, redirect_valid_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  trap_valid_i, trap_cause_i, trap_pc_i, mret_valid_i, irq_timer_i,
           csr_mstatus_i, csr_mtvec_i, csr_mepc_i, redirect_ready_i,
    output req_ready_o, csr_wen_o, csr_waddr_o, csr_wdata_o, csr_waddr_add1_o,
           csr_wdata_add1_o, redirect_valid_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/ysyx_exu_trap_ctrl_vec.sv
// Trap target calculation: direct base, or base + 4*code for vectored interrupts.
module ysyx_exu_trap_ctrl_vec
  import ysyx_exu_trap_ctrl_pkg::*;
#(
  parameter int BIT_W = 32
) (
  input  logic [BIT_W-1:0] mtvec,
  input  logic [BIT_W-1:0] cause,
  output logic [BIT_W-1:0] target
);
  logic [BIT_W-1:0] base;
  logic [BIT_W-1:0] offset;

  // Exception code shifted by 4-byte slots; the top code bits fall off (mod 2^BIT_W).
  assign base   = {mtvec[BIT_W-1:2], 2'b00};
  assign offset = BIT_W'({cause[BIT_W-2:0], 2'b00});
  assign target = (mtvec[1:0] == MTVEC_MODE_VEC && cause[BIT_W-1]) ? base + offset : base;

endmodule

// File: rtl/ysyx_exu_trap_ctrl.sv
// Machine-mode trap/mret sequencer: arbitrates irq/trap/mret, drives the CSR dual
// write port over a fixed multi-cycle sequence, then issues one fetch redirect.
module ysyx_exu_trap_ctrl
  import ysyx_exu_trap_ctrl_pkg::*;
#(
  parameter int               BIT_W     = 32,
  parameter int               R_W       = 12,
  parameter logic [BIT_W-1:0] IRQ_CAUSE = BIT_W'(IRQ_CAUSE_DEF)
) (
  input logic                clk,
  input logic                rst,
  ysyx_exu_trap_ctrl_if.slave bus
);
  trap_state_e      state, state_nxt;
  logic [BIT_W-1:0] pc_p0;
  logic [BIT_W-1:0] cause_p0;
  logic [BIT_W-1:0] target_p0;
  logic [BIT_W-1:0] vec_pc;
  logic             idle, irq_take, trap_take, mret_take;

  function automatic logic [BIT_W-1:0] mstatus_on_trap(input logic [BIT_W-1:0] s);
    logic [BIT_W-1:0] r;
    r = s;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  function automatic logic [BIT_W-1:0] mstatus_on_mret(input logic [BIT_W-1:0] s);
    logic [BIT_W-1:0] r;
    r = s;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  // Acceptance is blocked during reset so the EXU never sees a ready that is dropped.
  assign idle      = (state == ST_IDLE) && !rst;
  assign irq_take  = idle && bus.irq_timer_i && bus.csr_mstatus_i[MSTATUS_MIE];
  assign trap_take = idle && !irq_take && bus.trap_valid_i;
  assign mret_take = idle && !irq_take && !bus.trap_valid_i && bus.mret_valid_i;

  ysyx_exu_trap_ctrl_vec #(.BIT_W(BIT_W)) u_vec (
    .mtvec  (bus.csr_mtvec_i),
    .cause  (cause_p0),
    .target (vec_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc_p0     <= '0;
      cause_p0  <= '0;
      target_p0 <= '0;
    end else begin
      state <= state_nxt;
      if (irq_take || trap_take) begin
        pc_p0    <= bus.trap_pc_i;
        cause_p0 <= irq_take ? IRQ_CAUSE : bus.trap_cause_i;
      end
      if (mret_take) begin
        target_p0 <= bus.csr_mepc_i;
      end else if (state == ST_STAT) begin
        target_p0 <= vec_pc;
      end
    end
  end

  always_comb begin
    state_nxt            = state;
    bus.req_ready_o      = 1'b0;
    bus.csr_wen_o        = 1'b0;
    bus.csr_waddr_o      = '0;
    bus.csr_wdata_o      = '0;
    bus.csr_waddr_add1_o = '0;
    bus.csr_wdata_add1_o = '0;
    bus.redirect_valid_o = 1'b0;
    bus.redirect_pc_o    = '0;
    bus.busy_o           = 1'b1;
    case (state)
      ST_IDLE: begin
        bus.busy_o = 1'b0;
        if (irq_take || trap_take) begin
          bus.req_ready_o = 1'b1;
          state_nxt       = ST_SAVE;
        end else if (mret_take) begin
          bus.req_ready_o = 1'b1;
          state_nxt       = ST_MRET;
        end
      end
      ST_SAVE: begin
        bus.csr_wen_o        = 1'b1;
        bus.csr_waddr_o      = R_W'(CSR_MEPC);
        bus.csr_wdata_o      = pc_p0;
        bus.csr_waddr_add1_o = R_W'(CSR_MCAUSE);
        bus.csr_wdata_add1_o = cause_p0;
        state_nxt            = ST_STAT;
      end
      ST_STAT: begin
        bus.csr_wen_o   = 1'b1;
        bus.csr_waddr_o = R_W'(CSR_MSTATUS);
        bus.csr_wdata_o = mstatus_on_trap(bus.csr_mstatus_i);
        state_nxt       = ST_REDIR;
      end
      ST_MRET: begin
        bus.csr_wen_o   = 1'b1;
        bus.csr_waddr_o = R_W'(CSR_MSTATUS);
        bus.csr_wdata_o = mstatus_on_mret(bus.csr_mstatus_i);
        state_nxt       = ST_REDIR;
      end
      ST_REDIR: begin
        bus.redirect_valid_o = 1'b1;
        bus.redirect_pc_o    = target_p0;
        if (bus.redirect_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_exu_trap_ctrl.sv
// Directed bench for ysyx_exu_trap_ctrl: a table of full trap/mret sequences plus
// hand-written corner sequences (masked irq, redirect stall, reset mid-sequence, trap+mret).
module tb_ysyx_exu_trap_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_exu_trap_ctrl_if #(.BIT_W(32), .R_W(12)) bif ();

  ysyx_exu_trap_ctrl #(.BIT_W(32), .R_W(12), .IRQ_CAUSE(32'h8000_0007)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    string       name;
    logic        irq;
    logic        trap;
    logic        mret;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] exp_cause;
    logic [31:0] exp_mstatus;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bif.trap_valid_i = 1'b0;
    bif.mret_valid_i = 1'b0;
    bif.irq_timer_i  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bif.csr_mstatus_i    = v.mstatus;
    bif.csr_mtvec_i      = v.mtvec;
    bif.csr_mepc_i       = v.mepc;
    bif.trap_cause_i     = v.cause;
    bif.trap_pc_i        = v.pc;
    bif.irq_timer_i      = v.irq;
    bif.trap_valid_i     = v.trap;
    bif.mret_valid_i     = v.mret;
    bif.redirect_ready_i = 1'b0;
    sample();
    chk1({v.name, " req_ready"}, bif.req_ready_o, 1'b1);
    chk1({v.name, " idle busy"}, bif.busy_o, 1'b0);
    next_cycle();
    clear_reqs();
    sample();
    if (!v.mret) begin
      chk1({v.name, " save wen"}, bif.csr_wen_o, 1'b1);
      chk32({v.name, " save waddr"}, 32'(bif.csr_waddr_o), 32'h341);
      chk32({v.name, " save mepc"}, bif.csr_wdata_o, v.pc);
      chk32({v.name, " save waddr1"}, 32'(bif.csr_waddr_add1_o), 32'h342);
      chk32({v.name, " save mcause"}, bif.csr_wdata_add1_o, v.exp_cause);
      chk1({v.name, " save busy"}, bif.busy_o, 1'b1);
      next_cycle();
      sample();
    end
    chk1({v.name, " stat wen"}, bif.csr_wen_o, 1'b1);
    chk32({v.name, " stat waddr"}, 32'(bif.csr_waddr_o), 32'h300);
    chk32({v.name, " mstatus"}, bif.csr_wdata_o, v.exp_mstatus);
    chk32({v.name, " stat waddr1"}, 32'(bif.csr_waddr_add1_o), 32'h0);
    chk1({v.name, " stat redirect"}, bif.redirect_valid_o, 1'b0);
    next_cycle();
    bif.redirect_ready_i = 1'b1;
    sample();
    chk1({v.name, " redir valid"}, bif.redirect_valid_o, 1'b1);
    chk32({v.name, " redir pc"}, bif.redirect_pc_o, v.exp_pc);
    chk1({v.name, " redir wen"}, bif.csr_wen_o, 1'b0);
    chk1({v.name, " redir busy"}, bif.busy_o, 1'b1);
    next_cycle();
    bif.redirect_ready_i = 1'b0;
    sample();
    chk1({v.name, " done busy"}, bif.busy_o, 1'b0);
    chk1({v.name, " done valid"}, bif.redirect_valid_o, 1'b0);
  endtask

  initial begin
    //            name         irq   trap  mret  cause         pc            mstatus       mtvec         mepc          exp_cause     exp_mstatus   exp_pc
    vecs[0] = '{"ecall",      1'b0, 1'b1, 1'b0, 32'd11,       32'h8000_0100, 32'h0000_0008, 32'h8000_0400, 32'h0,        32'd11,       32'h0000_1880, 32'h8000_0400};
    vecs[1] = '{"vec_irq",    1'b1, 1'b0, 1'b0, 32'd0,        32'h8000_0200, 32'h0000_0008, 32'h8000_0401, 32'h0,        32'h8000_0007, 32'h0000_1880, 32'h8000_041C};
    vecs[2] = '{"mret",       1'b0, 1'b0, 1'b1, 32'd0,        32'h0,         32'h0000_0080, 32'h8000_0400, 32'h8000_0104, 32'h0,        32'h0000_1888, 32'h8000_0104};
    vecs[3] = '{"illegal",    1'b0, 1'b1, 1'b0, 32'd2,        32'h8000_1000, 32'hA000_0000, 32'h8000_0501, 32'h0,        32'd2,        32'hA000_1800, 32'h8000_0500};
    vecs[4] = '{"irq_vs_trap",1'b1, 1'b1, 1'b0, 32'd11,       32'h8000_0300, 32'h0000_0088, 32'h8000_0400, 32'h0,        32'h8000_0007, 32'h0000_1880, 32'h8000_0400};
    vecs[5] = '{"ebreak_ones",1'b0, 1'b1, 1'b0, 32'd3,        32'h8000_0008, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0,        32'd3,        32'hFFFF_FFF7, 32'hFFFF_FFFC};
    vecs[6] = '{"irq_wrap",   1'b1, 1'b0, 1'b0, 32'd0,        32'h8000_0400, 32'h0000_0008, 32'hFFFF_FFF1, 32'h0,        32'h8000_0007, 32'h0000_1880, 32'h0000_000C};
    vecs[7] = '{"mret_mpie0", 1'b0, 1'b0, 1'b1, 32'd0,        32'h0,         32'h0000_0008, 32'h8000_0400, 32'h0000_2000, 32'h0,        32'h0000_1880, 32'h0000_2000};

    rst = 1'b1;
    clear_reqs();
    bif.trap_cause_i     = '0;
    bif.trap_pc_i        = '0;
    bif.csr_mstatus_i    = '0;
    bif.csr_mtvec_i      = '0;
    bif.csr_mepc_i       = '0;
    bif.redirect_ready_i = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b0;
    sample();
    chk1("rst req_ready", bif.req_ready_o, 1'b0);
    chk1("rst wen", bif.csr_wen_o, 1'b0);
    chk32("rst waddr", 32'(bif.csr_waddr_o), 32'h0);
    chk32("rst waddr1", 32'(bif.csr_waddr_add1_o), 32'h0);
    chk1("rst redirect", bif.redirect_valid_o, 1'b0);
    chk32("rst redirect_pc", bif.redirect_pc_o, 32'h0);
    chk1("rst busy", bif.busy_o, 1'b0);

    for (int i = 0; i < 8; i++) begin
      next_cycle();
      run_vec(vecs[i]);
    end

    // Masked interrupt: MIE=0 keeps the sequencer idle.
    next_cycle();
    bif.csr_mstatus_i = 32'h0000_0080;
    bif.irq_timer_i   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample();
      chk1("masked req_ready", bif.req_ready_o, 1'b0);
      chk1("masked wen", bif.csr_wen_o, 1'b0);
      next_cycle();
    end
    clear_reqs();

    // Redirect back-pressure: hold ready low for 5 cycles.
    bif.csr_mstatus_i = 32'h0000_0008;
    bif.csr_mtvec_i   = 32'h8000_0400;
    bif.trap_cause_i  = 32'd11;
    bif.trap_pc_i     = 32'h8000_0100;
    bif.trap_valid_i  = 1'b1;
    sample();
    chk1("stall accept", bif.req_ready_o, 1'b1);
    next_cycle();
    clear_reqs();
    next_cycle();
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk1("stall valid", bif.redirect_valid_o, 1'b1);
      chk32("stall pc", bif.redirect_pc_o, 32'h8000_0400);
      chk1("stall busy", bif.busy_o, 1'b1);
      next_cycle();
    end
    bif.redirect_ready_i = 1'b1;
    sample();
    chk1("stall release valid", bif.redirect_valid_o, 1'b1);
    next_cycle();
    bif.redirect_ready_i = 1'b0;
    sample();
    chk1("stall idle busy", bif.busy_o, 1'b0);
    chk1("stall idle valid", bif.redirect_valid_o, 1'b0);

    // Reset while in STAT aborts the sequence.
    next_cycle();
    bif.trap_valid_i = 1'b1;
    sample();
    chk1("rst-seq accept", bif.req_ready_o, 1'b1);
    next_cycle();
    clear_reqs();
    next_cycle();
    rst = 1'b1;
    sample();
    chk1("rst-seq stat wen", bif.csr_wen_o, 1'b1);
    next_cycle();
    rst = 1'b0;
    sample();
    chk1("rst-seq wen", bif.csr_wen_o, 1'b0);
    chk1("rst-seq redirect", bif.redirect_valid_o, 1'b0);
    chk1("rst-seq busy", bif.busy_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample();
      chk1("rst-seq quiet wen", bif.csr_wen_o, 1'b0);
    end

    // Simultaneous trap+mret: trap first, mret stays pending and follows.
    next_cycle();
    bif.csr_mstatus_i    = 32'h0000_0008;
    bif.csr_mepc_i       = 32'h8000_0104;
    bif.trap_cause_i     = 32'd11;
    bif.trap_pc_i        = 32'h8000_0500;
    bif.trap_valid_i     = 1'b1;
    bif.mret_valid_i     = 1'b1;
    sample();
    chk1("both accept", bif.req_ready_o, 1'b1);
    next_cycle();
    bif.trap_valid_i = 1'b0;
    sample();
    chk32("both save waddr", 32'(bif.csr_waddr_o), 32'h341);
    chk32("both save mepc", bif.csr_wdata_o, 32'h8000_0500);
    chk1("both held mret ignored", bif.req_ready_o, 1'b0);
    next_cycle();
    next_cycle();
    bif.redirect_ready_i = 1'b1;
    sample();
    chk32("both trap redir", bif.redirect_pc_o, 32'h8000_0400);
    next_cycle();
    bif.redirect_ready_i = 1'b0;
    sample();
    chk1("both mret accept", bif.req_ready_o, 1'b1);
    next_cycle();
    bif.mret_valid_i = 1'b0;
    sample();
    chk32("both mret waddr", 32'(bif.csr_waddr_o), 32'h300);
    chk32("both mret mstatus", bif.csr_wdata_o, 32'h0000_1880);
    next_cycle();
    bif.redirect_ready_i = 1'b1;
    sample();
    chk1("both mret redir valid", bif.redirect_valid_o, 1'b1);
    chk32("both mret redir pc", bif.redirect_pc_o, 32'h8000_0104);
    next_cycle();
    bif.redirect_ready_i = 1'b0;
    sample();
    chk1("both final busy", bif.busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
